lc3_control_fsm: RTL and testbench

LC3_CONTROL_FSM -- requirements
Module: lc3_control_fsm

---
 rtl/lc3_pkg.sv | 69 ++++++
 rtl/lc3_control_fsm_wait_counter.sv | 36 +++
 rtl/lc3_control_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared definitions for the LC-3 control FSM: the state
//               enumeration, the opcode constants the decoder dispatches on,
//               and the encodings of the PCMUX, ADDR2MUX and ALUK selects.
// Revision    : 1.0  initial release
// ============================================================================
package lc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED   = 5'd0,
        S_FETCH1   = 5'd1,
        S_FETCH2   = 5'd2,
        S_FETCH3   = 5'd3,
        S_DECODE   = 5'd4,
        S_ADD      = 5'd5,
        S_AND      = 5'd6,
        S_NOT      = 5'd7,
        S_BR       = 5'd8,
        S_BR_TAKEN = 5'd9,
        S_JMP      = 5'd10,
        S_JSR1     = 5'd11,
        S_JSR2     = 5'd12,
        S_LDR1     = 5'd13,
        S_LDR2     = 5'd14,
        S_LDR3     = 5'd15,
        S_STR1     = 5'd16,
        S_STR2     = 5'd17,
        S_STR3     = 5'd18,
        S_PAUSE1   = 5'd19,
        S_PAUSE2   = 5'd20
    } state_t;

    // Opcodes (IR[15:12]) with a dedicated execute path; all others are NOPs.
    localparam logic [3:0] c_OP_BR    = 4'b0000;
    localparam logic [3:0] c_OP_ADD   = 4'b0001;
    localparam logic [3:0] c_OP_JSR   = 4'b0100;
    localparam logic [3:0] c_OP_AND   = 4'b0101;
    localparam logic [3:0] c_OP_LDR   = 4'b0110;
    localparam logic [3:0] c_OP_STR   = 4'b0111;
    localparam logic [3:0] c_OP_NOT   = 4'b1001;
    localparam logic [3:0] c_OP_JMP   = 4'b1100;
    localparam logic [3:0] c_OP_PAUSE = 4'b1101;

    // PC source
    localparam logic [1:0] c_PCMUX_INC   = 2'b00;   // PC + 1
    localparam logic [1:0] c_PCMUX_BASER = 2'b01;   // BaseR
    localparam logic [1:0] c_PCMUX_ADDER = 2'b10;   // address adder

    // Second address-adder operand
    localparam logic [1:0] c_ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] c_ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] c_ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] c_ADDR2_OFF11 = 2'b11;

    // ALU operation
    localparam logic [1:0] c_ALUK_ADD  = 2'b00;
    localparam logic [1:0] c_ALUK_AND  = 2'b01;
    localparam logic [1:0] c_ALUK_NOT  = 2'b10;
    localparam logic [1:0] c_ALUK_PASS = 2'b11;

    // States that hold a memory strobe for MEM_WAIT cycles.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH2) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage : lc3_pkg
`default_nettype wire

// File: rtl/lc3_control_fsm_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : wait_counter
// Description : Memory wait-state counter. Cleared while i_load is high,
//               counts up while i_enable is high and saturates once o_done
//               is reached. o_done is high in the COUNT-th enabled cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_load        - clear the count
//               i_enable      - advance the count
//               o_done        - final wait cycle reached
// Revision    : 1.0  initial release
// ============================================================================
module wait_counter #(
    parameter int COUNT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_enable,
    output logic o_done
);

    logic [2:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_count <= 3'd0;
        end else if (i_enable && !o_done) begin
            r_count <= r_count + 3'd1;
        end
    end

    assign o_done = (r_count == 3'(COUNT - 1));

endmodule : wait_counter
`default_nettype wire

// File: rtl/lc3_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : lc3_control_fsm
// Description : Moore control unit for a reduced LC-3 datapath. Sequences
//               fetch/decode/execute for ADD, AND, NOT, BR, JMP, JSR/JSRR,
//               LDR, STR and a PAUSE instruction, and drives the SRAM strobes.
// Ports       : Clk, Reset            - clock, synchronous active-high reset
//               Run, Continue         - start from HALTED, release from PAUSE
//               Opcode, IR_5, IR_11   - instruction fields
//               BEN                   - registered branch enable
//               LD_*                  - register loads
//               Gate*                 - bus drivers
//               PCMUX..ALUK           - datapath selects
//               Mem_CE/UB/LB/OE/WE    - active-low SRAM controls
// Revision    : 1.0  initial release
// ============================================================================
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_UB,
    output logic       Mem_LB,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t r_state;
    state_t w_next_state;
    logic   w_cnt_load;
    logic   w_cnt_en;
    logic   w_cnt_done;

    // The counter runs only inside a memory wait state and is held clear
    // everywhere else, so it always starts from zero on entry.
    assign w_cnt_en   = is_mem_wait_state(r_state);
    assign w_cnt_load = !w_cnt_en;

    wait_counter #(
        .COUNT(MEM_WAIT)
    ) u_wait_counter (
        .clk     (Clk),
        .rst     (Reset),
        .i_load  (w_cnt_load),
        .i_enable(w_cnt_en),
        .o_done  (w_cnt_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_HALTED;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HALTED:   if (Run) w_next_state = S_FETCH1;
            S_FETCH1:   w_next_state = S_FETCH2;
            S_FETCH2:   if (w_cnt_done) w_next_state = S_FETCH3;
            S_FETCH3:   w_next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    c_OP_ADD:   w_next_state = S_ADD;
                    c_OP_AND:   w_next_state = S_AND;
                    c_OP_NOT:   w_next_state = S_NOT;
                    c_OP_BR:    w_next_state = S_BR;
                    c_OP_JMP:   w_next_state = S_JMP;
                    c_OP_JSR:   w_next_state = S_JSR1;
                    c_OP_LDR:   w_next_state = S_LDR1;
                    c_OP_STR:   w_next_state = S_STR1;
                    c_OP_PAUSE: w_next_state = S_PAUSE1;
                    default:    w_next_state = S_FETCH1;
                endcase
            end
            // BEN was loaded in DECODE, so it is settled by the time BR samples it.
            S_BR:       w_next_state = BEN ? S_BR_TAKEN : S_FETCH1;
            S_JSR1:     w_next_state = S_JSR2;
            S_LDR1:     w_next_state = S_LDR2;
            S_LDR2:     if (w_cnt_done) w_next_state = S_LDR3;
            S_STR1:     w_next_state = S_STR2;
            S_STR2:     w_next_state = S_STR3;
            S_STR3:     if (w_cnt_done) w_next_state = S_FETCH1;
            S_PAUSE1:   if (Continue) w_next_state = S_PAUSE2;
            S_PAUSE2:   if (!Continue) w_next_state = S_FETCH1;
            S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR2, S_LDR3:
                        w_next_state = S_FETCH1;
            default:    w_next_state = S_HALTED;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. SR2MUX and the JSR/JSRR selects pass IR bits through;
    // those bits are held stable by the IR for the whole instruction.
    // ------------------------------------------------------------------
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = c_PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = c_ADDR2_ZERO;
        ALUK       = c_ALUK_ADD;
        Mem_CE     = 1'b1;
        Mem_UB     = 1'b1;
        Mem_LB     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        if (r_state != S_HALTED) begin
            Mem_CE = 1'b0;
            Mem_UB = 1'b0;
            Mem_LB = 1'b0;
        end

        case (r_state)
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = c_PCMUX_INC;
            end
            S_FETCH2, S_LDR2: begin
                Mem_OE = 1'b0;
                LD_MDR = 1'b1;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (r_state == S_ADD) ? c_ALUK_ADD :
                          (r_state == S_AND) ? c_ALUK_AND : c_ALUK_NOT;
            end
            S_BR_TAKEN: begin
                LD_PC    = 1'b1;
                PCMUX    = c_PCMUX_ADDER;
                ADDR1MUX = 1'b0;
                ADDR2MUX = c_ADDR2_OFF9;
            end
            S_JMP: begin
                LD_PC = 1'b1;
                PCMUX = c_PCMUX_BASER;
            end
            S_JSR1: begin
                GatePC = 1'b1;
                LD_REG = 1'b1;
                DRMUX  = 1'b1;          // destination R7
            end
            S_JSR2: begin
                LD_PC = 1'b1;
                if (IR_11) begin
                    PCMUX    = c_PCMUX_ADDER;
                    ADDR1MUX = 1'b0;
                    ADDR2MUX = c_ADDR2_OFF11;
                end else begin
                    PCMUX = c_PCMUX_BASER;
                end
            end
            S_LDR1, S_STR1: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                ADDR1MUX   = 1'b1;      // BaseR
                ADDR2MUX   = c_ADDR2_OFF6;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_STR2: begin
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                ALUK    = c_ALUK_PASS;
                SR1MUX  = 1'b1;         // source register is IR[11:9]
            end
            S_STR3:   Mem_WE = 1'b0;
            S_PAUSE1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule : lc3_control_fsm
`default_nettype wire

// File: tb/tb_lc3_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_control_fsm
// Description : Self-checking bench for lc3_control_fsm. An instruction-level
//               reference model expands each opcode into its expected
//               sequence of per-cycle control words; table vectors and
//               random instructions are run against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lc3_control_fsm;

    localparam int MW = 2;

    logic       Clk = 1'b0;
    logic       Reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    lc3_control_fsm #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB),
        .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic ce, ub, lb, oe, we;
    } ctrl_t;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic       ir5, ir11, ben;
        int         p1, h;
        int         exp_pc, exp_oe, exp_we, exp_led, exp_cc;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    ctrl_t eq[$];
    logic  cq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic ctrl_t dut_word();
        ctrl_t c;
        c.ld_mar = LD_MAR;  c.ld_mdr = LD_MDR;  c.ld_ir = LD_IR;   c.ld_ben = LD_BEN;
        c.ld_cc = LD_CC;    c.ld_reg = LD_REG;  c.ld_pc = LD_PC;   c.ld_led = LD_LED;
        c.gate_pc = GatePC; c.gate_mdr = GateMDR; c.gate_alu = GateALU;
        c.gate_marmux = GateMARMUX; c.pcmux = PCMUX; c.drmux = DRMUX;
        c.sr1mux = SR1MUX;  c.sr2mux = SR2MUX;  c.addr1mux = ADDR1MUX;
        c.addr2mux = ADDR2MUX; c.aluk = ALUK;
        c.ce = Mem_CE; c.ub = Mem_UB; c.lb = Mem_LB; c.oe = Mem_OE; c.we = Mem_WE;
        return c;
    endfunction

    // Running, no activity: chip enabled, strobes idle.
    function automatic ctrl_t idle();
        ctrl_t c = '0;
        c.oe = 1'b1;
        c.we = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t halted_w();
        ctrl_t c = idle();
        c.ce = 1'b1; c.ub = 1'b1; c.lb = 1'b1;
        return c;
    endfunction

    task automatic push(input ctrl_t w, input logic cont);
        eq.push_back(w);
        cq.push_back(cont);
    endtask

    // Reference model: the expected control word of every cycle of one
    // instruction, from FETCH1 up to (not including) the next FETCH1,
    // together with the Continue value to drive in each cycle.
    task automatic build(input logic [3:0] op, input logic ir5, input logic ir11,
                         input logic ben, input int p1, input int h);
        ctrl_t w;
        eq.delete();
        cq.delete();
        w = idle(); w.gate_pc = 1; w.ld_mar = 1; w.ld_pc = 1; push(w, 0);
        w = idle(); w.oe = 0; w.ld_mdr = 1;  repeat (MW) push(w, 0);
        w = idle(); w.gate_mdr = 1; w.ld_ir = 1; push(w, 0);
        w = idle(); w.ld_ben = 1; push(w, 0);
        case (op)
            4'd1, 4'd5, 4'd9: begin
                w = idle(); w.gate_alu = 1; w.ld_reg = 1; w.ld_cc = 1; w.sr2mux = ir5;
                w.aluk = (op == 4'd1) ? 2'd0 : (op == 4'd5) ? 2'd1 : 2'd2;
                push(w, 0);
            end
            4'd0: begin
                push(idle(), 0);
                if (ben) begin
                    w = idle(); w.ld_pc = 1; w.pcmux = 2; w.addr2mux = 2; push(w, 0);
                end
            end
            4'd12: begin
                w = idle(); w.ld_pc = 1; w.pcmux = 1; push(w, 0);
            end
            4'd4: begin
                w = idle(); w.gate_pc = 1; w.ld_reg = 1; w.drmux = 1; push(w, 0);
                w = idle(); w.ld_pc = 1;
                if (ir11) begin w.pcmux = 2; w.addr2mux = 3; end
                else w.pcmux = 1;
                push(w, 0);
            end
            4'd6, 4'd7: begin
                w = idle(); w.gate_marmux = 1; w.ld_mar = 1; w.addr1mux = 1; w.addr2mux = 1;
                push(w, 0);
                if (op == 4'd6) begin
                    w = idle(); w.oe = 0; w.ld_mdr = 1; repeat (MW) push(w, 0);
                    w = idle(); w.gate_mdr = 1; w.ld_reg = 1; w.ld_cc = 1; push(w, 0);
                end else begin
                    w = idle(); w.gate_alu = 1; w.ld_mdr = 1; w.aluk = 3; w.sr1mux = 1;
                    push(w, 0);
                    w = idle(); w.we = 0; repeat (MW) push(w, 0);
                end
            end
            4'd13: begin
                w = idle(); w.ld_led = 1;
                repeat (p1) push(w, 0);
                push(w, 1);                       // Continue rises: leave PAUSE1
                repeat (h - 1) push(idle(), 1);   // PAUSE2 while Continue held
                push(idle(), 0);                  // Continue falls: leave PAUSE2
            end
            default: ;
        endcase
    endtask

    // Runs one instruction starting in FETCH1; every cycle is compared with
    // the model and checked for the strobe/load exclusions.
    task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ir11,
                             input logic ben, input int p1, input int h,
                             output int n_pc, output int n_oe, output int n_we,
                             output int n_led, output int n_cc);
        ctrl_t d;
        Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
        build(op, ir5, ir11, ben, p1, h);
        n_pc = 0; n_oe = 0; n_we = 0; n_led = 0; n_cc = 0;
        for (int i = 0; i < eq.size(); i++) begin
            d = dut_word();
            check($sformatf("op%0h_cycle%0d", op, i), 64'(d), 64'(eq[i]));
            check("ldcc_ldben_excl", 64'(LD_CC & LD_BEN), 64'd0);
            check("oe_we_excl", 64'(!Mem_OE & !Mem_WE), 64'd0);
            n_pc  += int'(LD_PC);
            n_oe  += int'(!Mem_OE);
            n_we  += int'(!Mem_WE);
            n_led += int'(LD_LED);
            n_cc  += int'(LD_CC);
            Continue = cq[i];
            Run = 1'($urandom);                   // must be ignored while running
            @(negedge Clk);
        end
        Run = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        int k, n_pc, n_oe, n_we, n_led, n_cc;

        tbl[0]  = '{"add_imm",  4'd1,  1, 0, 0, 0, 0, 1, MW,   0,  0, 1};
        tbl[1]  = '{"and_reg",  4'd5,  0, 0, 0, 0, 0, 1, MW,   0,  0, 1};
        tbl[2]  = '{"not",      4'd9,  1, 1, 0, 0, 0, 1, MW,   0,  0, 1};
        tbl[3]  = '{"br_taken", 4'd0,  0, 0, 1, 0, 0, 2, MW,   0,  0, 0};
        tbl[4]  = '{"br_not",   4'd0,  0, 0, 0, 0, 0, 1, MW,   0,  0, 0};
        tbl[5]  = '{"jmp",      4'd12, 0, 0, 0, 0, 0, 2, MW,   0,  0, 0};
        tbl[6]  = '{"jsr",      4'd4,  0, 1, 0, 0, 0, 2, MW,   0,  0, 0};
        tbl[7]  = '{"jsrr",     4'd4,  0, 0, 0, 0, 0, 2, MW,   0,  0, 0};
        tbl[8]  = '{"ldr",      4'd6,  0, 0, 0, 0, 0, 1, 2*MW, 0,  0, 1};
        tbl[9]  = '{"str",      4'd7,  0, 0, 0, 0, 0, 1, MW,   MW, 0, 0};
        tbl[10] = '{"pause",    4'd13, 0, 0, 0, 3, 2, 1, MW,   0,  4, 0};
        tbl[11] = '{"nop",      4'd3,  0, 0, 1, 0, 0, 1, MW,   0,  0, 0};

        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        Opcode = 4'd3; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_state", 64'(dut_word()), 64'(halted_w()));
        Reset = 1'b0;
        Continue = 1'b1;
        @(negedge Clk);
        check("halted_hold", 64'(dut_word()), 64'(halted_w()));
        Continue = 1'b0;

        // Run pulse: LD_IR must show MW+2 cycles after the Run cycle.
        Run = 1'b1;
        k = 0;
        do begin
            @(negedge Clk);
            Run = 1'b0;
            k++;
        end while (!LD_IR && k < 10);
        check("ld_ir_latency", 64'(k), 64'(MW + 2));
        repeat (2) @(negedge Clk);               // DECODE of a NOP, then FETCH1

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].op, tbl[i].ir5, tbl[i].ir11, tbl[i].ben, tbl[i].p1,
                      tbl[i].h, n_pc, n_oe, n_we, n_led, n_cc);
            check({tbl[i].name, "_ldpc_cycles"}, 64'(n_pc), 64'(tbl[i].exp_pc));
            check({tbl[i].name, "_oe_cycles"},   64'(n_oe), 64'(tbl[i].exp_oe));
            check({tbl[i].name, "_we_cycles"},   64'(n_we), 64'(tbl[i].exp_we));
            check({tbl[i].name, "_led_cycles"},  64'(n_led), 64'(tbl[i].exp_led));
            check({tbl[i].name, "_ldcc_cycles"}, 64'(n_cc), 64'(tbl[i].exp_cc));
        end

        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                      1'($urandom), $urandom_range(0, 3), $urandom_range(1, 3),
                      n_pc, n_oe, n_we, n_led, n_cc);
        end

        // Reset in the middle of a store write strobe.
        Opcode = 4'd7;
        repeat (MW + 5) @(negedge Clk);
        check("str3_we_low", 64'(Mem_WE), 64'd0);
        check("str3_oe_high", 64'(Mem_OE), 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_mid_str3", 64'(dut_word()), 64'(halted_w()));
        Reset = 1'b0;
        Continue = 1'b1;
        repeat (2) @(negedge Clk);
        check("halted_after_reset", 64'(dut_word()), 64'(halted_w()));
        Continue = 1'b0;

        // Restart: the wait counter must begin from zero again.
        Opcode = 4'd1;
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        run_instr(4'd1, 1'b1, 1'b0, 1'b0, 0, 1, n_pc, n_oe, n_we, n_led, n_cc);
        check("restart_oe_cycles", 64'(n_oe), 64'(MW));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lc3_control_fsm
`default_nettype wire
